// File: rtl/cpu_pkg.sv
// Shared widths and phase encodings for the 4-bit CPU datapath.
// Every instruction is a fetch phase followed by an execute phase.
package cpu_pkg;
    localparam int PC_W   = 12;
    localparam int BYTE_W = 8;
    localparam int NIB_W  = BYTE_W / 2;

    localparam logic PHASE_FETCH = 1'b0;
    localparam logic PHASE_EXEC  = 1'b1;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch <-> Decode/ROM/ALU signal bundle; master drives Decode/ALU/ROM inputs,
// slave is the fetch unit.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic              enable;
    logic [BYTE_W-1:0] program_byte;
    logic              incPC;
    logic              loadPC;
    logic              loadFlags;
    logic              alu_C;
    logic              alu_Ze;

    logic [PC_W-1:0]   PC;
    logic [NIB_W-1:0]  instr;
    logic [NIB_W-1:0]  oprnd;
    logic [PC_W-1:0]   address;
    logic              phase;
    logic              C;
    logic              Ze;

    modport master (
        output enable, program_byte, incPC, loadPC, loadFlags, alu_C, alu_Ze,
        input  PC, instr, oprnd, address, phase, C, Ze
    );

    modport slave (
        input  enable, program_byte, incPC, loadPC, loadFlags, alu_C, alu_Ze,
        output PC, instr, oprnd, address, phase, C, Ze
    );
endinterface

// File: rtl/reg_en.sv
// Enable-gated D register with synchronous active-high clear.
// One cycle latency; holds its value while i_en is low.
module reg_en #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, phase toggle, fetch register and C/Ze flags; all state
// updates on clk when enable is high, address is a zero-latency combine.
module fetch_unit
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_next;
    logic              w_phase;
    logic              w_phase_next;
    logic [BYTE_W-1:0] w_fetch;
    logic [1:0]        w_flags;
    logic [PC_W-1:0]   w_address;
    logic              w_fetch_en;
    logic              w_flags_en;

    // The opcode byte is captured only in fetch; in execute the ROM output
    // is the operand byte, which must not overwrite the opcode.
    assign w_phase_next = ~w_phase;
    assign w_fetch_en   = bus.enable && (w_phase == PHASE_FETCH);
    assign w_flags_en   = bus.enable && bus.loadFlags && (w_phase == PHASE_EXEC);
    assign w_address    = {w_fetch[NIB_W-1:0], bus.program_byte};

    reg_en #(.W(1)) u_phase (
        .clk   (clk),
        .reset (reset),
        .i_en  (bus.enable),
        .i_d   (w_phase_next),
        .o_q   (w_phase)
    );

    reg_en #(.W(BYTE_W)) u_fetch (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_fetch_en),
        .i_d   (bus.program_byte),
        .o_q   (w_fetch)
    );

    reg_en #(.W(2)) u_flags (
        .clk   (clk),
        .reset (reset),
        .i_en  (w_flags_en),
        .i_d   ({bus.alu_C, bus.alu_Ze}),
        .o_q   (w_flags)
    );

    // Load beats increment so a jump that also flags incPC still lands on target.
    always_comb begin
        w_pc_next = r_pc;
        if (bus.loadPC) begin
            w_pc_next = w_address;
        end else if (bus.incPC) begin
            w_pc_next = r_pc + PC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= '0;
        end else if (bus.enable) begin
            r_pc <= w_pc_next;
        end
    end

    assign bus.PC      = r_pc;
    assign bus.instr   = w_fetch[BYTE_W-1:NIB_W];
    assign bus.oprnd   = w_fetch[NIB_W-1:0];
    assign bus.address = w_address;
    assign bus.phase   = w_phase;
    assign bus.C       = w_flags[1];
    assign bus.Ze      = w_flags[0];
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: each task drives one scenario and checks
// the registered outputs one time unit after the rising edge.
module tb_fetch_unit;
    logic clk;
    logic reset;
    int   tests;
    int   failures;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.incPC     = 1'b0;
        bus.loadPC    = 1'b0;
        bus.loadFlags = 1'b0;
        bus.alu_C     = 1'b0;
        bus.alu_Ze    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b1;
        idle_inputs();
        bus.program_byte = 8'hA5;
        step();
        reset = 1'b0;
        tests++; if (bus.PC    !== 12'h000) begin failures++; $display("FAIL reset_pc: got %h want %h", bus.PC, 12'h000); end
        tests++; if (bus.phase !== 1'b0)    begin failures++; $display("FAIL reset_phase: got %b want %b", bus.phase, 1'b0); end
        tests++; if (bus.instr !== 4'h0)    begin failures++; $display("FAIL reset_instr: got %h want %h", bus.instr, 4'h0); end
        tests++; if (bus.oprnd !== 4'h0)    begin failures++; $display("FAIL reset_oprnd: got %h want %h", bus.oprnd, 4'h0); end
        tests++; if (bus.C     !== 1'b0)    begin failures++; $display("FAIL reset_C: got %b want %b", bus.C, 1'b0); end
        tests++; if (bus.Ze    !== 1'b0)    begin failures++; $display("FAIL reset_Ze: got %b want %b", bus.Ze, 1'b0); end
    endtask

    // Phase 0 fetch of 8'h4A with incPC; then address shows {oprnd, next byte}.
    task automatic test_fetch();
        bus.program_byte = 8'h4A;
        bus.incPC = 1'b1;
        step();
        idle_inputs();
        tests++; if (bus.instr !== 4'h4)    begin failures++; $display("FAIL fetch_instr: got %h want %h", bus.instr, 4'h4); end
        tests++; if (bus.oprnd !== 4'hA)    begin failures++; $display("FAIL fetch_oprnd: got %h want %h", bus.oprnd, 4'hA); end
        tests++; if (bus.PC    !== 12'h001) begin failures++; $display("FAIL fetch_pc: got %h want %h", bus.PC, 12'h001); end
        tests++; if (bus.phase !== 1'b1)    begin failures++; $display("FAIL fetch_phase: got %b want %b", bus.phase, 1'b1); end
        bus.program_byte = 8'h45;
        #1;
        tests++; if (bus.address !== 12'hA45) begin failures++; $display("FAIL fetch_address: got %h want %h", bus.address, 12'hA45); end
    endtask

    // Phase 1 with incPC consumes the operand byte, then a jump with both loadPC and incPC.
    task automatic test_load_priority();
        bus.incPC = 1'b1;
        step();
        tests++; if (bus.PC    !== 12'h002) begin failures++; $display("FAIL twobyte_pc: got %h want %h", bus.PC, 12'h002); end
        tests++; if (bus.phase !== 1'b0)    begin failures++; $display("FAIL twobyte_phase: got %b want %b", bus.phase, 1'b0); end
        bus.program_byte = 8'h73;
        bus.incPC = 1'b1;
        step();
        tests++; if (bus.PC    !== 12'h003) begin failures++; $display("FAIL jmp_fetch_pc: got %h want %h", bus.PC, 12'h003); end
        bus.program_byte = 8'h45;
        bus.loadPC = 1'b1;
        bus.incPC  = 1'b1;
        #1;
        tests++; if (bus.address !== 12'h345) begin failures++; $display("FAIL jmp_address: got %h want %h", bus.address, 12'h345); end
        step();
        idle_inputs();
        tests++; if (bus.PC    !== 12'h345) begin failures++; $display("FAIL jmp_pc: got %h want %h", bus.PC, 12'h345); end
        tests++; if (bus.instr !== 4'h7)    begin failures++; $display("FAIL jmp_instr_held: got %h want %h", bus.instr, 4'h7); end
        tests++; if (bus.oprnd !== 4'h3)    begin failures++; $display("FAIL jmp_oprnd_held: got %h want %h", bus.oprnd, 4'h3); end
        tests++; if (bus.phase !== 1'b0)    begin failures++; $display("FAIL jmp_phase: got %b want %b", bus.phase, 1'b0); end
    endtask

    task automatic test_wrap();
        bus.program_byte = 8'hFF;
        step();
        bus.loadPC = 1'b1;
        step();
        idle_inputs();
        tests++; if (bus.PC !== 12'hFFF) begin failures++; $display("FAIL wrap_setup_pc: got %h want %h", bus.PC, 12'hFFF); end
        bus.incPC = 1'b1;
        step();
        idle_inputs();
        tests++; if (bus.PC !== 12'h000) begin failures++; $display("FAIL wrap_pc: got %h want %h", bus.PC, 12'h000); end
    endtask

    // Starts in phase 1; loads in phase 0 must be ignored.
    task automatic test_flags();
        step();
        bus.loadFlags = 1'b1; bus.alu_C = 1'b1; bus.alu_Ze = 1'b1;
        step();
        tests++; if (bus.C  !== 1'b0) begin failures++; $display("FAIL flags_ph0_C: got %b want %b", bus.C, 1'b0); end
        tests++; if (bus.Ze !== 1'b0) begin failures++; $display("FAIL flags_ph0_Ze: got %b want %b", bus.Ze, 1'b0); end
        step();
        tests++; if (bus.C  !== 1'b1) begin failures++; $display("FAIL flags_ph1_C: got %b want %b", bus.C, 1'b1); end
        tests++; if (bus.Ze !== 1'b1) begin failures++; $display("FAIL flags_ph1_Ze: got %b want %b", bus.Ze, 1'b1); end
        bus.alu_C = 1'b0; bus.alu_Ze = 1'b0;
        step();
        tests++; if (bus.C  !== 1'b1) begin failures++; $display("FAIL flags_ph0b_C: got %b want %b", bus.C, 1'b1); end
        bus.alu_C = 1'b0; bus.alu_Ze = 1'b1;
        step();
        idle_inputs();
        tests++; if (bus.C  !== 1'b0) begin failures++; $display("FAIL flags_split_C: got %b want %b", bus.C, 1'b0); end
        tests++; if (bus.Ze !== 1'b1) begin failures++; $display("FAIL flags_split_Ze: got %b want %b", bus.Ze, 1'b1); end
        tests++; if (bus.phase !== 1'b0) begin failures++; $display("FAIL flags_phase: got %b want %b", bus.phase, 1'b0); end
    endtask

    task automatic test_freeze();
        bus.program_byte = 8'h5C;
        bus.incPC = 1'b1;
        step();
        bus.enable = 1'b0;
        bus.program_byte = 8'h00;
        for (int i = 0; i < 3; i++) begin
            bus.incPC     = (i != 1);
            bus.loadPC    = (i != 0);
            bus.loadFlags = 1'b1;
            bus.alu_C     = 1'b1;
            bus.alu_Ze    = 1'b0;
            step();
        end
        tests++; if (bus.PC    !== 12'h001) begin failures++; $display("FAIL freeze_pc: got %h want %h", bus.PC, 12'h001); end
        tests++; if (bus.phase !== 1'b1)    begin failures++; $display("FAIL freeze_phase: got %b want %b", bus.phase, 1'b1); end
        tests++; if (bus.instr !== 4'h5)    begin failures++; $display("FAIL freeze_instr: got %h want %h", bus.instr, 4'h5); end
        tests++; if (bus.oprnd !== 4'hC)    begin failures++; $display("FAIL freeze_oprnd: got %h want %h", bus.oprnd, 4'hC); end
        tests++; if (bus.C     !== 1'b0)    begin failures++; $display("FAIL freeze_C: got %b want %b", bus.C, 1'b0); end
        tests++; if (bus.Ze    !== 1'b1)    begin failures++; $display("FAIL freeze_Ze: got %b want %b", bus.Ze, 1'b1); end
        bus.enable = 1'b1;
        bus.program_byte = 8'h99;
        bus.incPC = 1'b1; bus.loadPC = 1'b0;
        bus.loadFlags = 1'b1; bus.alu_C = 1'b1; bus.alu_Ze = 1'b0;
        step();
        idle_inputs();
        tests++; if (bus.phase !== 1'b0)    begin failures++; $display("FAIL resume_phase: got %b want %b", bus.phase, 1'b0); end
        tests++; if (bus.PC    !== 12'h002) begin failures++; $display("FAIL resume_pc: got %h want %h", bus.PC, 12'h002); end
        tests++; if (bus.instr !== 4'h5)    begin failures++; $display("FAIL resume_instr: got %h want %h", bus.instr, 4'h5); end
        tests++; if (bus.C     !== 1'b1)    begin failures++; $display("FAIL resume_C: got %b want %b", bus.C, 1'b1); end
        tests++; if (bus.Ze    !== 1'b0)    begin failures++; $display("FAIL resume_Ze: got %b want %b", bus.Ze, 1'b0); end
    endtask

    // Reach PC=12'h123 in phase 1 with flags set, then reset while enable is low.
    task automatic test_reset_mid();
        bus.program_byte = 8'h01;
        step();
        bus.program_byte = 8'h23;
        bus.loadPC = 1'b1;
        step();
        idle_inputs();
        bus.program_byte = 8'hB7;
        step();
        tests++; if (bus.PC    !== 12'h123) begin failures++; $display("FAIL rstmid_setup_pc: got %h want %h", bus.PC, 12'h123); end
        tests++; if (bus.phase !== 1'b1)    begin failures++; $display("FAIL rstmid_setup_phase: got %b want %b", bus.phase, 1'b1); end
        tests++; if (bus.instr !== 4'hB)    begin failures++; $display("FAIL rstmid_setup_instr: got %h want %h", bus.instr, 4'hB); end
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.incPC = 1'b1; bus.loadFlags = 1'b1; bus.alu_C = 1'b1; bus.alu_Ze = 1'b1;
        step();
        reset = 1'b0;
        bus.enable = 1'b1;
        idle_inputs();
        tests++; if (bus.PC    !== 12'h000) begin failures++; $display("FAIL rstmid_pc: got %h want %h", bus.PC, 12'h000); end
        tests++; if (bus.phase !== 1'b0)    begin failures++; $display("FAIL rstmid_phase: got %b want %b", bus.phase, 1'b0); end
        tests++; if (bus.instr !== 4'h0)    begin failures++; $display("FAIL rstmid_instr: got %h want %h", bus.instr, 4'h0); end
        tests++; if (bus.oprnd !== 4'h0)    begin failures++; $display("FAIL rstmid_oprnd: got %h want %h", bus.oprnd, 4'h0); end
        tests++; if (bus.C     !== 1'b0)    begin failures++; $display("FAIL rstmid_C: got %b want %b", bus.C, 1'b0); end
        tests++; if (bus.Ze    !== 1'b0)    begin failures++; $display("FAIL rstmid_Ze: got %b want %b", bus.Ze, 1'b0); end
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        reset    = 1'b1;
        bus.enable       = 1'b0;
        bus.program_byte = 8'h00;
        idle_inputs();
        test_reset();
        test_fetch();
        test_load_priority();
        test_wrap();
        test_flags();
        test_freeze();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
